vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 177 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync/blank and tracks timing lock.
// Optional per-frame colour checksum is built when VGA_DEC_FRAME_SUM_EN is defined.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        blank_n,
    input  logic [7:0]  color_in,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [7:0]  pixel_color,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error,
    output logic [10:0] line_period,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        hsync_s1, vsync_s1, blank_s1, hsync_s2, vsync_s2;
    logic [7:0]  color_s1;
    logic        h_fall, v_fall;
    logic [9:0]  x_cnt, y_cnt, x_eff, x_nxt, y_line, y_eff;
    logic [10:0] p_cnt;
    logic [3:0]  good_cnt, good_nxt;
    logic        frame_bad, frame_bad_nxt;
    logic        line_bad, frame_is_bad, err_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_s1 <= 1'b1;
            vsync_s1 <= 1'b1;
            hsync_s2 <= 1'b1;
            vsync_s2 <= 1'b1;
            blank_s1 <= 1'b0;
            color_s1 <= '0;
        end else begin
            hsync_s1 <= hsync_n;
            vsync_s1 <= vsync_n;
            hsync_s2 <= hsync_s1;
            vsync_s2 <= vsync_s1;
            blank_s1 <= blank_n;
            color_s1 <= color_in;
        end
    end

    assign h_fall = hsync_s2 & ~hsync_s1;
    assign v_fall = vsync_s2 & ~vsync_s1;

    // The line closed by an hsync edge is accounted before a coincident vsync edge clears y.
    always_comb begin
        x_eff        = h_fall ? '0 : x_cnt;
        x_nxt        = (blank_s1 && (x_eff != '1)) ? x_eff + 10'd1 : x_eff;
        y_line       = (h_fall && (x_cnt != '0) && (y_cnt != '1)) ? y_cnt + 10'd1 : y_cnt;
        y_eff        = v_fall ? '0 : y_line;
        line_bad     = h_fall && (((x_cnt != '0) && (x_cnt != 10'(H_ACTIVE))) ||
                                  (p_cnt != 11'(H_TOTAL)));
        frame_is_bad = frame_bad | line_bad | (y_line != 10'(V_ACTIVE));
    end

    always_comb begin
        state_nxt     = state;
        good_nxt      = good_cnt;
        frame_bad_nxt = frame_bad | line_bad;
        err_nxt       = 1'b0;

        if (state == LOCKED && line_bad) begin
            state_nxt = SEARCH;
            err_nxt   = 1'b1;
        end

        // Frame close is applied on top of the line-close result.
        if (v_fall) begin
            frame_bad_nxt = 1'b0;
            case (state_nxt)
                SEARCH: begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
                TRACK: begin
                    if (frame_is_bad) begin
                        good_nxt = '0;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= 4'(LOCK_FRAMES)) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (frame_is_bad) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            frame_bad   <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            p_cnt       <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= '0;
            frame_start <= 1'b0;
            sync_error  <= 1'b0;
            locked      <= 1'b0;
            line_period <= '0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            frame_bad   <= frame_bad_nxt;
            x_cnt       <= x_nxt;
            y_cnt       <= y_eff;
            if (h_fall) begin
                p_cnt       <= 11'd1;
                line_period <= p_cnt;
            end else if (p_cnt != '1) begin
                p_cnt <= p_cnt + 11'd1;
            end
            pixel_valid <= blank_s1;
            pixel_x     <= x_eff;
            pixel_y     <= y_eff;
            pixel_color <= color_s1;
            frame_start <= v_fall;
            sync_error  <= err_nxt;
            locked      <= (state_nxt == LOCKED);
        end
    end

`ifdef VGA_DEC_FRAME_SUM_EN
    logic [15:0] sum_acc;
    logic        seen_vfall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_acc         <= '0;
            seen_vfall      <= 1'b0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= v_fall & seen_vfall;
            if (v_fall) begin
                seen_vfall <= 1'b1;
                if (seen_vfall) begin
                    frame_sum <= sum_acc;
                end
                sum_acc <= blank_s1 ? 16'(color_s1) : '0;
            end else if (blank_s1) begin
                sum_acc <= sum_acc + 16'(color_s1);
            end
        end
    end
`else
    assign frame_sum       = '0;
    assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down video timing.
module tb_vga_sync_decoder;

    localparam int HA = 20;
    localparam int VA = 6;
    localparam int HT = 32;
    localparam int VT = 10;
    localparam int NV = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_n = 1'b1, vsync_n = 1'b1, blank_n = 1'b0;
    logic [7:0]  color_in = '0;
    logic        pixel_valid, frame_start, locked, sync_error, frame_sum_valid;
    logic [9:0]  pixel_x, pixel_y;
    logic [7:0]  pixel_color;
    logic [10:0] line_period;
    logic [15:0] frame_sum;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .LOCK_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .blank_n(blank_n), .color_in(color_in), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .frame_start(frame_start), .locked(locked), .sync_error(sync_error),
        .line_period(line_period), .frame_sum(frame_sum),
        .frame_sum_valid(frame_sum_valid)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stream position and observed events
    int vc_g = 0, line_g = 0, vfalls_in = 0;
    int short_line = -1, long_line = -1;
    int err_cnt = 0, err_line = -1, lock_at = -1, fs_line = -1, first_y = -1;
    logic want_y = 1'b0, locked_d = 1'b0;

    // Frame checksum reference model
    logic        m_prev_vs = 1'b1, m_first = 1'b1;
    logic [15:0] m_acc = '0;
    logic [15:0] sum_q[$];

    task automatic model_reset();
        m_prev_vs = 1'b1;
        m_first   = 1'b1;
        m_acc     = '0;
        sum_q.delete();
    endtask

    task automatic drive(input logic hs, input logic vs, input logic bl, input logic [7:0] col);
        @(negedge clock);
        hsync_n  = hs;
        vsync_n  = vs;
        blank_n  = bl;
        color_in = col;
        if (m_prev_vs && !vs) begin
            if (!m_first) sum_q.push_back(m_acc);
            m_first = 1'b0;
            m_acc   = bl ? 16'(col) : 16'd0;
        end else if (bl) begin
            m_acc = m_acc + 16'(col);
        end
        m_prev_vs = vs;
    endtask

    task automatic send_line(input int vc);
        int act, extra;
        act   = (line_g == short_line) ? HA - 1 : HA;
        extra = (line_g == long_line) ? 1 : 0;
        for (int hc = 0; hc < HT + extra; hc++) begin
            if (vc == 7 && hc == 0) vfalls_in++;
            drive(!(hc >= 24 && hc < 28), !(vc >= 7 && vc < 9),
                  (vc < VA) && (hc < act), 8'h01);
        end
        line_g++;
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) begin
            send_line(vc_g);
            vc_g = (vc_g + 1) % VT;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0; color_in = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        vc_g = 0; line_g = 0; vfalls_in = 0;
        err_cnt = 0; err_line = -1; lock_at = -1;
        short_line = -1; long_line = -1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sync_error) begin
                err_cnt++;
                err_line = line_g;
            end
            if (locked && !locked_d) lock_at = vfalls_in;
            if (frame_start && fs_line < 0) fs_line = vc_g;
            if (pixel_valid && want_y) begin
                first_y = int'(pixel_y);
                want_y  = 1'b0;
            end
`ifdef VGA_DEC_FRAME_SUM_EN
            if (frame_sum_valid) begin
                if (sum_q.size() == 0) check("frame_sum_valid_unexpected", 32'(frame_sum_valid), 32'd0);
                else check("frame_sum", 32'(frame_sum), 32'(sum_q.pop_front()));
            end
`else
            if (frame_start) begin
                check("frame_sum_off", 32'(frame_sum), 32'd0);
                check("frame_sum_valid_off", 32'(frame_sum_valid), 32'd0);
            end
`endif
        end
        locked_d = locked;
    end

    typedef struct packed {
        logic hs, vs, bl;
        logic [7:0] col;
        logic ev;
        logic [9:0] ex, ey;
        logic efs;
        logic chk_lp;
        logic [10:0] elp;
    } vec_t;

    function automatic vec_t mk(input int hs, input int vs, input int bl, input int col,
                                input int ev, input int ex, input int ey, input int efs,
                                input int lp);
        vec_t r;
        r.hs = (hs != 0); r.vs = (vs != 0); r.bl = (bl != 0); r.col = 8'(col);
        r.ev = (ev != 0); r.ex = 10'(ex); r.ey = 10'(ey); r.efs = (efs != 0);
        r.chk_lp = (lp >= 0); r.elp = 11'(lp < 0 ? 0 : lp);
        return r;
    endfunction

    vec_t vec [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            hs vs bl col    v  x  y fs  lp
        vec[0]  = mk(1, 1, 0, 'h00,  0, 0, 0, 0,  0);
        vec[1]  = mk(1, 1, 1, 'h11,  1, 0, 0, 0,  0);
        vec[2]  = mk(1, 1, 1, 'h22,  1, 1, 0, 0,  0);
        vec[3]  = mk(1, 1, 1, 'h33,  1, 2, 0, 0,  0);
        vec[4]  = mk(1, 1, 0, 'h00,  0, 3, 0, 0,  0);
        vec[5]  = mk(0, 1, 0, 'h00,  0, 0, 1, 0, -1);
        vec[6]  = mk(1, 1, 0, 'h00,  0, 0, 1, 0, -1);
        vec[7]  = mk(1, 1, 1, 'h44,  1, 0, 1, 0, -1);
        vec[8]  = mk(1, 1, 1, 'h55,  1, 1, 1, 0, -1);
        vec[9]  = mk(0, 1, 0, 'h00,  0, 0, 2, 0,  4);
        vec[10] = mk(1, 1, 0, 'h00,  0, 0, 2, 0,  4);
        vec[11] = mk(0, 1, 1, 'h66,  1, 0, 2, 0,  2);
        vec[12] = mk(1, 0, 1, 'h77,  1, 1, 0, 1,  2);
        vec[13] = mk(0, 0, 0, 'h00,  0, 0, 1, 0,  2);
        vec[14] = mk(1, 1, 1, 'h88,  1, 0, 1, 0,  2);
        vec[15] = mk(0, 0, 1, 'h99,  1, 0, 0, 1,  2);

        // Outputs while reset is held
        repeat (2) @(negedge clock);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_line_period", 32'(line_period), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0;

        // Pixel pipeline: record i appears on the outputs two clocks later
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) drive(vec[i].hs, vec[i].vs, vec[i].bl, vec[i].col);
            else drive(1'b1, 1'b1, 1'b0, 8'h00);
            if (i >= 2) begin
                check($sformatf("vec%0d_valid", i-2), 32'(pixel_valid), 32'(vec[i-2].ev));
                check($sformatf("vec%0d_x", i-2), 32'(pixel_x), 32'(vec[i-2].ex));
                check($sformatf("vec%0d_y", i-2), 32'(pixel_y), 32'(vec[i-2].ey));
                check($sformatf("vec%0d_color", i-2), 32'(pixel_color), 32'(vec[i-2].col));
                check($sformatf("vec%0d_frame_start", i-2), 32'(frame_start), 32'(vec[i-2].efs));
                if (vec[i-2].chk_lp)
                    check($sformatf("vec%0d_line_period", i-2), 32'(line_period), 32'(vec[i-2].elp));
            end
        end

        // Clean stream: lock after the 3rd vsync falling edge
        do_reset();
        run_lines(27);
        check("a_locked_before_3rd_vfall", 32'(locked), 32'd0);
        run_lines(3);
        check("a_locked", 32'(locked), 32'd1);
        check("a_lock_at_vfall", 32'(lock_at), 32'd3);
        check("a_sync_errors", 32'(err_cnt), 32'd0);
        check("a_line_period", 32'(line_period), 32'(HT));

        // Short line while locked
        short_line = 32;
        run_lines(3);
        check("b_sync_errors", 32'(err_cnt), 32'd1);
        check("b_error_line", 32'(err_line), 32'd32);
        check("b_locked_dropped", 32'(locked), 32'd0);
        run_lines(27);
        check("b_relocked", 32'(locked), 32'd1);
        check("b_relock_at_vfall", 32'(lock_at), 32'd6);
        check("b_sync_errors_total", 32'(err_cnt), 32'd1);

        // Long line in TRACK delays lock by one frame
        do_reset();
        long_line = 12;
        run_lines(37);
        check("c_locked_delayed", 32'(locked), 32'd0);
        run_lines(3);
        check("c_locked", 32'(locked), 32'd1);
        check("c_lock_at_vfall", 32'(lock_at), 32'd4);
        check("c_sync_errors", 32'(err_cnt), 32'd0);

        // Asynchronous reset mid-line while locked
        run_lines(3);
        for (int hc = 0; hc < 10; hc++) drive(1'b1, 1'b1, 1'b1, 8'h01);
        check("d_locked_pre", 32'(locked), 32'd1);
        check("d_valid_pre", 32'(pixel_valid), 32'd1);
        #2;
        reset   = 1'b1;
        blank_n = 1'b0;
        #1;
        check("d_pixel_valid", 32'(pixel_valid), 32'd0);
        check("d_pixel_x", 32'(pixel_x), 32'd0);
        check("d_pixel_y", 32'(pixel_y), 32'd0);
        check("d_pixel_color", 32'(pixel_color), 32'd0);
        check("d_locked", 32'(locked), 32'd0);
        check("d_line_period", 32'(line_period), 32'd0);
        check("d_frame_start", 32'(frame_start), 32'd0);
        check("d_sync_error", 32'(sync_error), 32'd0);
        check("d_frame_sum", 32'(frame_sum), 32'd0);
        check("d_frame_sum_valid", 32'(frame_sum_valid), 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        fs_line = -1;
        want_y  = 1'b1;
        vc_g    = 4;
        run_lines(7);
        check("d_first_y", 32'(first_y), 32'd0);
        check("d_frame_start_line", 32'(fs_line), 32'd7);

        // Far corner: 479 one-pixel lines, then a 640-pixel line
        do_reset();
        for (int l = 0; l < 479; l++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h01);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
        end
        for (int j = 0; j < 640; j++) drive(1'b1, 1'b1, 1'b1, (j == 639) ? 8'hA5 : 8'h01);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("e_valid", 32'(pixel_valid), 32'd1);
        check("e_x639", 32'(pixel_x), 32'd639);
        check("e_y479", 32'(pixel_y), 32'd479);
        check("e_color", 32'(pixel_color), 32'hA5);
        for (int j = 0; j < 460; j++) drive(1'b1, 1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("e_x_saturated", 32'(pixel_x), 32'd1023);

`ifdef VGA_DEC_FRAME_SUM_EN
        check("frame_sum_pending", 32'(sum_q.size()), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
